cvp14_memory: RTL and testbench
===============================

// Module: cvp14_memory
// PURPOSE
// Unified instruction/data word memory directly downstream of the CVP14 core. Serves core
// fetch/VLD/VST traffic on Addr/RD/WR with one-cycle read latency, latches sticky V/error
// status, and gives a host (bench or loader) a four-phase port to preload programs and dump results.
// PARAMETERS
// DEPTH   4096  words implemented; word addresses >= DEPTH are out of range
// DATA_W  16    word width; fixed to match the core
// ADDR_W  16    core/host address width
// PORTS
// Clk1       in   1       sole clock, rising edge
// Reset      in   1       asynchronous, active-low; 0 = reset
// Addr       in   ADDR_W  core word address
// RD         in   1       core read strobe
// WR         in   1       core write strobe
// CoreWData  in   DATA_W  core write data (core dataOut)
// CoreRData  out  DATA_W  read data to core DataIn
// V          in   1       core over/underflow indication
// HostMode   in   1       1 = host owns memory; core strobes ignored
// HostReq    in   1       host request, four-phase
// HostWe     in   1       1 = host write, 0 = host read
// HostAddr   in   ADDR_W  host word address
// HostWData  in   DATA_W  host write data
// HostAck    out  1       host acknowledge
// HostRData  out  DATA_W  host read data, valid while HostAck=1
// StatusClr  in   1       host clears sticky flags (honoured only when HostMode=1)
// OvfFlag    out  1       sticky: V seen high
// RangeErr   out  1       sticky: core access at address >= DEPTH
// Conflict   out  1       sticky: RD and WR high in the same cycle
// BEHAVIOUR
// - Reset low: CoreRData=0, HostRData=0, HostAck=0, all sticky flags 0, host FSM IDLE.
//   Array contents are not reset; they persist across reset.
// - Core read: RD=1 in cycle N -> mem[Addr] registered at the edge ending N, valid through N+1.
//   CoreRData holds its last value while RD=0, so the core samples it in Decode/Load.
// - Core write: WR=1 -> mem[Addr]<=CoreWData at the edge ending the cycle. A read of the
//   same address in the following cycle returns the new data.
// - RD&WR both 1: write performed, CoreRData holds, Conflict set.
// - Addr >= DEPTH: write dropped, read returns 16'h0000, RangeErr set. No wrap-around.
// - V=1 at any edge sets OvfFlag. Set beats clear: StatusClr and a set event in the same
//   cycle leave the flag at 1.
// - HostMode=1: core RD/WR ignored, no flags updated by core, CoreRData holds.
// - Host FSM:
//   - IDLE -> ACCESS on HostReq&HostMode; latch HostWe/HostAddr/HostWData.
//   - ACCESS performs one array access -> ACK.
//   - ACK: HostAck=1 with HostRData valid; stay until HostReq=0, then IDLE.
//   - Host reads of out-of-range addresses return 0; host writes to them are dropped.
//     Host accesses never set RangeErr.
// - HostMode falls in ACCESS/ACK: abort to IDLE, HostAck=0 next cycle. A write latched into
//   ACCESS completes only if HostMode is still 1 in that cycle.
// - Reset mid-transaction: FSM returns to IDLE asynchronously. An in-flight write is not
//   guaranteed to land.
// STRUCTURE
// - Shared package cvp14_pkg: DATA_W, ADDR_W, and the host FSM state enum
//   (HOST_IDLE, HOST_ACCESS, HOST_ACK).
// - One sub-module: cvp14_word_ram (single-port synchronous array with registered read data
//   and no reset). Arbitration mux, host FSM and sticky flags live in this module.
// TESTING
// - Reset, host writes 16'h1234 @5, host reads @5 -> HostAck after 2 cycles, HostRData=16'h1234.
// - HostMode=0, RD=1 Addr=5 in cycle N -> CoreRData=16'h1234 in N+1; RD=0 in N+1 -> value holds.
// - WR=1 Addr=7 data 16'hBEEF, then RD Addr=7 next cycle -> CoreRData=16'hBEEF.
//   16 consecutive VST-style writes 0x20..0x2F then reads -> all words match.
// - RD=1 Addr=DEPTH -> CoreRData=0, RangeErr=1. WR=1 Addr=DEPTH -> no array word changes.
//   RD&WR same cycle -> Conflict=1.
// - V pulse one cycle -> OvfFlag=1 and stays; HostMode=1 with StatusClr=1 -> all flags 0.
//   StatusClr coincident with V=1 -> OvfFlag stays 1.
// - Host read in ACK, HostMode dropped -> HostAck=0 next cycle, FSM IDLE.
//   Reset low mid-ACK -> HostAck=0 immediately; memory contents preserved after reset.

Source files
------------

// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 unified word memory.
//   DATA_W / ADDR_W : word and address widths fixed by the core
//   MEM_DEPTH       : default number of implemented words
//   host_state_t    : host port FSM state encoding
package cvp14_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 4096;

    typedef enum logic [1:0] {
        HOST_IDLE   = 2'd0,
        HOST_ACCESS = 2'd1,
        HOST_ACK    = 2'd2
    } host_state_t;

endpackage

// File: rtl/cvp14_word_ram.sv
// Single-port synchronous word array with registered read data.
// Neither the array nor the read register is reset, so contents survive a reset.
//   i_clk   : clock, rising edge
//   i_en    : access enable
//   i_we    : 1 = write i_wdata, 0 = read into o_rdata
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : read data, updated only by a read; holds across writes and idle cycles
module cvp14_word_ram
    import cvp14_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cvp14_memory.sv
// Unified instruction/data memory for the CVP14 core with a host load/dump port.
//   Clk1, Reset            : clock (rising edge), async active-low reset
//   Addr, RD, WR           : core word address and strobes
//   CoreWData / CoreRData  : core write data / read data (one-cycle latency, holds when idle)
//   V                      : core over/underflow indication
//   HostMode               : 1 = host owns the array, core strobes ignored
//   HostReq/HostAck        : four-phase host handshake
//   HostWe/HostAddr/HostWData/HostRData : host transfer fields
//   StatusClr              : host clear of sticky flags (only while HostMode=1)
//   OvfFlag/RangeErr/Conflict : sticky status
//   DbgHostState           : host FSM state, for observation only
module cvp14_memory
    import cvp14_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              RD,
    input  logic              WR,
    input  logic [DATA_W-1:0] CoreWData,
    output logic [DATA_W-1:0] CoreRData,
    input  logic              V,
    input  logic              HostMode,
    input  logic              HostReq,
    input  logic              HostWe,
    input  logic [ADDR_W-1:0] HostAddr,
    input  logic [DATA_W-1:0] HostWData,
    output logic              HostAck,
    output logic [DATA_W-1:0] HostRData,
    input  logic              StatusClr,
    output logic              OvfFlag,
    output logic              RangeErr,
    output logic              Conflict,
    output logic [1:0]        DbgHostState
);

    localparam int                RAM_AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT  = ADDR_W'(DEPTH);

    // Host handshake: the host raises HostReq with HostWe/HostAddr/HostWData
    // stable; the request is latched on the first edge. HostAck rises once the
    // access is done and HostRData is valid for as long as HostAck stays 1.
    // The host then drops HostReq and HostAck falls on the following edge.
    // Dropping HostMode at any point abandons the transfer.
    host_state_t       r_state;
    logic              r_host_we;
    logic [ADDR_W-1:0] r_host_addr;
    logic [DATA_W-1:0] r_host_wdata;
    logic              r_host_ack;
    logic              r_host_first;   // first ACK cycle: read data still comes from the array register
    logic              r_host_rd_ok;   // the ACK concerns an in-range read
    logic [DATA_W-1:0] r_host_rdata;

    logic              r_core_pend;    // a core read was issued last cycle
    logic [DATA_W-1:0] r_core_rdata;

    logic              r_ovf;
    logic              r_range;
    logic              r_conf;

    logic              w_core_act;
    logic              w_core_oor;
    logic              w_core_wr;
    logic              w_core_rd;
    logic              w_host_oor;
    logic              w_host_go;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [RAM_AW-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_host_q;
    logic              w_clr;

    // Core and host never reach the array in the same cycle: the core needs
    // HostMode=0, the host access needs HostMode=1.
    assign w_core_act = ~HostMode;
    assign w_core_oor = (Addr >= LIMIT);
    assign w_core_wr  = w_core_act & WR & ~w_core_oor;
    assign w_core_rd  = w_core_act & RD & ~WR & ~w_core_oor;

    assign w_host_oor = (r_host_addr >= LIMIT);
    assign w_host_go  = (r_state == HOST_ACCESS) & HostMode & ~w_host_oor;

    assign w_ram_en    = w_core_wr | w_core_rd | w_host_go;
    assign w_ram_we    = w_host_go ? r_host_we : w_core_wr;
    assign w_ram_addr  = w_host_go ? r_host_addr[RAM_AW-1:0] : Addr[RAM_AW-1:0];
    assign w_ram_wdata = w_host_go ? r_host_wdata : CoreWData;

    cvp14_word_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .i_clk   (Clk1),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    // Array read register feeds the ports directly in the cycle after a read;
    // afterwards the captured copy holds the value.
    assign CoreRData = r_core_pend ? w_ram_q : r_core_rdata;
    assign w_host_q  = r_host_rd_ok ? w_ram_q : '0;
    assign HostRData = r_host_first ? w_host_q : r_host_rdata;
    assign HostAck   = r_host_ack;
    assign DbgHostState = r_state;

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            r_core_pend  <= 1'b0;
            r_core_rdata <= '0;
        end else begin
            r_core_pend <= w_core_rd;
            if (r_core_pend) begin
                r_core_rdata <= w_ram_q;
            end
            // Out-of-range read returns zero; it overrides any capture above.
            if (w_core_act & RD & ~WR & w_core_oor) begin
                r_core_rdata <= '0;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    assign w_clr = StatusClr & HostMode;

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            r_ovf   <= 1'b0;
            r_range <= 1'b0;
            r_conf  <= 1'b0;
        end else begin
            r_ovf   <= V | (r_ovf & ~w_clr);
            r_range <= (w_core_act & (RD | WR) & w_core_oor) | (r_range & ~w_clr);
            r_conf  <= (w_core_act & RD & WR) | (r_conf & ~w_clr);
        end
    end

    assign OvfFlag  = r_ovf;
    assign RangeErr = r_range;
    assign Conflict = r_conf;

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            r_state      <= HOST_IDLE;
            r_host_we    <= 1'b0;
            r_host_addr  <= '0;
            r_host_wdata <= '0;
            r_host_ack   <= 1'b0;
            r_host_first <= 1'b0;
            r_host_rd_ok <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            case (r_state)
                HOST_IDLE: begin
                    r_host_ack   <= 1'b0;
                    r_host_first <= 1'b0;
                    if (HostReq & HostMode) begin
                        r_host_we    <= HostWe;
                        r_host_addr  <= HostAddr;
                        r_host_wdata <= HostWData;
                        r_state      <= HOST_ACCESS;
                    end
                end
                HOST_ACCESS: begin
                    if (HostMode) begin
                        r_host_ack   <= 1'b1;
                        r_host_first <= 1'b1;
                        r_host_rd_ok <= ~r_host_we & ~w_host_oor;
                        r_state      <= HOST_ACK;
                    end else begin
                        r_state <= HOST_IDLE;
                    end
                end
                HOST_ACK: begin
                    r_host_first <= 1'b0;
                    if (r_host_first) begin
                        r_host_rdata <= w_host_q;
                    end
                    if (~HostMode | ~HostReq) begin
                        r_host_ack <= 1'b0;
                        r_state    <= HOST_IDLE;
                    end
                end
                default: begin
                    r_host_ack   <= 1'b0;
                    r_host_first <= 1'b0;
                    r_state      <= HOST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cvp14_memory.sv
module tb_cvp14_memory;
  import cvp14_pkg::*;

  localparam int DEPTH = 4096;

  logic              Clk1 = 1'b0;
  logic              Reset;
  logic [15:0]       Addr;
  logic              RD;
  logic              WR;
  logic [15:0]       CoreWData;
  logic [15:0]       CoreRData;
  logic              V;
  logic              HostMode;
  logic              HostReq;
  logic              HostWe;
  logic [15:0]       HostAddr;
  logic [15:0]       HostWData;
  logic              HostAck;
  logic [15:0]       HostRData;
  logic              StatusClr;
  logic              OvfFlag;
  logic              RangeErr;
  logic              Conflict;
  logic [1:0]        DbgHostState;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_q[$];

  cvp14_memory #(.DEPTH(DEPTH)) dut (
    .Clk1         (Clk1),
    .Reset        (Reset),
    .Addr         (Addr),
    .RD           (RD),
    .WR           (WR),
    .CoreWData    (CoreWData),
    .CoreRData    (CoreRData),
    .V            (V),
    .HostMode     (HostMode),
    .HostReq      (HostReq),
    .HostWe       (HostWe),
    .HostAddr     (HostAddr),
    .HostWData    (HostWData),
    .HostAck      (HostAck),
    .HostRData    (HostRData),
    .StatusClr    (StatusClr),
    .OvfFlag      (OvfFlag),
    .RangeErr     (RangeErr),
    .Conflict     (Conflict),
    .DbgHostState (DbgHostState)
  );

  // clock / reset
  always #5 Clk1 = ~Clk1;

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic core_write(input logic [15:0] a, input logic [15:0] d);
    Addr = a; CoreWData = d; WR = 1'b1;
    tick();
    WR = 1'b0;
  endtask

  task automatic core_read(input logic [15:0] a, output logic [15:0] d);
    Addr = a; RD = 1'b1;
    tick();
    RD = 1'b0;
    d = CoreRData;
  endtask

  task automatic host_xfer(input logic we, input logic [15:0] a, input logic [15:0] wd,
                           output logic [15:0] rd, output int lat);
    HostReq = 1'b1; HostWe = we; HostAddr = a; HostWData = wd;
    lat = 0;
    while (!HostAck && lat < 8) begin
      tick();
      lat++;
    end
    chk("host_ack_seen", 32'(HostAck), 32'd1);
    rd = HostRData;
    HostReq = 1'b0;
    tick();
    chk("host_ack_drop", 32'(HostAck), 32'd0);
  endtask

  logic [15:0] d;
  int          lat;

  initial begin
    Reset = 1'b0; Addr = '0; RD = 1'b0; WR = 1'b0; CoreWData = '0; V = 1'b0;
    HostMode = 1'b0; HostReq = 1'b0; HostWe = 1'b0; HostAddr = '0; HostWData = '0;
    StatusClr = 1'b0;
    repeat (3) tick();
    chk("rst_core_rdata", 32'(CoreRData), 32'h0);
    chk("rst_host_ack", 32'(HostAck), 32'h0);
    chk("rst_host_rdata", 32'(HostRData), 32'h0);
    chk("rst_flags", {29'd0, OvfFlag, RangeErr, Conflict}, 32'h0);
    chk("rst_state", 32'(DbgHostState), 32'(HOST_IDLE));
    Reset = 1'b1;
    tick();

    // host preload and readback
    HostMode = 1'b1;
    host_xfer(1'b1, 16'd5, 16'h1234, d, lat);
    host_xfer(1'b0, 16'd5, 16'h0000, d, lat);
    chk("host_rd_latency", 32'(lat), 32'd2);
    chk("host_rd_data", 32'(d), 32'h1234);

    // core read, then hold
    HostMode = 1'b0;
    tick();
    core_read(16'd5, d);
    chk("core_rd_5", 32'(d), 32'h1234);
    tick();
    chk("core_rd_hold", 32'(CoreRData), 32'h1234);

    // write-then-read
    core_write(16'd7, 16'hBEEF);
    core_read(16'd7, d);
    chk("core_rd_7", 32'(d), 32'hBEEF);

    // burst of 16 stores, then pipelined loads against the scoreboard
    for (int i = 0; i < 16; i++) begin
      Addr = 16'h0020 + 16'(i); CoreWData = 16'hC000 | 16'(i * 16'h0111); WR = 1'b1;
      exp_q.push_back(16'hC000 | 16'(i * 16'h0111));
      tick();
    end
    WR = 1'b0;
    for (int i = 0; i < 16; i++) begin
      Addr = 16'h0020 + 16'(i); RD = 1'b1;
      tick();
      chk("burst_rd", 32'(CoreRData), 32'(exp_q.pop_front()));
    end
    RD = 1'b0;
    chk("no_range_yet", 32'(RangeErr), 32'd0);
    chk("no_conflict_yet", 32'(Conflict), 32'd0);

    // out-of-range read and write
    core_read(16'(DEPTH), d);
    chk("oor_rd_zero", 32'(d), 32'h0);
    chk("oor_range_err", 32'(RangeErr), 32'd1);
    core_write(16'd0, 16'h5A5A);
    core_write(16'(DEPTH), 16'hDEAD);
    core_write(16'(DEPTH + 7), 16'hDEAD);
    core_read(16'd7, d);
    chk("oor_no_wrap_7", 32'(d), 32'hBEEF);
    core_read(16'd0, d);
    chk("oor_no_wrap_0", 32'(d), 32'h5A5A);

    // RD and WR together: write lands, read data holds
    Addr = 16'd9; CoreWData = 16'h9999; RD = 1'b1; WR = 1'b1;
    tick();
    RD = 1'b0; WR = 1'b0;
    chk("conf_flag", 32'(Conflict), 32'd1);
    chk("conf_rdata_hold", 32'(CoreRData), 32'h5A5A);
    core_read(16'd9, d);
    chk("conf_write_done", 32'(d), 32'h9999);

    // overflow flag
    V = 1'b1;
    tick();
    V = 1'b0;
    chk("ovf_set", 32'(OvfFlag), 32'd1);
    tick();
    chk("ovf_sticky", 32'(OvfFlag), 32'd1);
    StatusClr = 1'b1;
    tick();
    chk("clr_needs_hostmode", 32'(OvfFlag), 32'd1);
    HostMode = 1'b1;
    tick();
    chk("clr_all", {29'd0, OvfFlag, RangeErr, Conflict}, 32'h0);
    V = 1'b1;
    tick();
    V = 1'b0;
    chk("set_beats_clr", 32'(OvfFlag), 32'd1);
    tick();
    chk("clr_ovf", 32'(OvfFlag), 32'd0);
    StatusClr = 1'b0;

    // core strobes ignored in host mode
    Addr = 16'(DEPTH); RD = 1'b1; WR = 1'b1;
    tick();
    RD = 1'b0; WR = 1'b0;
    chk("hm_no_flags", {30'd0, RangeErr, Conflict}, 32'h0);
    chk("hm_rdata_hold", 32'(CoreRData), 32'h9999);

    // host out-of-range access
    host_xfer(1'b1, 16'(DEPTH + 5), 16'hFFFF, d, lat);
    host_xfer(1'b0, 16'd5, 16'h0000, d, lat);
    chk("host_oor_wr_dropped", 32'(d), 32'h1234);
    host_xfer(1'b0, 16'(DEPTH), 16'h0000, d, lat);
    chk("host_oor_rd_zero", 32'(d), 32'h0);
    chk("host_no_range_err", 32'(RangeErr), 32'd0);

    // abort in ACK by dropping HostMode
    HostReq = 1'b1; HostWe = 1'b0; HostAddr = 16'd5;
    tick();
    chk("abort_in_access", 32'(DbgHostState), 32'(HOST_ACCESS));
    tick();
    chk("abort_ack_up", 32'(HostAck), 32'd1);
    chk("abort_ack_data", 32'(HostRData), 32'h1234);
    HostMode = 1'b0;
    tick();
    chk("abort_ack_down", 32'(HostAck), 32'd0);
    chk("abort_idle", 32'(DbgHostState), 32'(HOST_IDLE));
    HostReq = 1'b0;
    tick();

    // asynchronous reset while in ACK
    HostMode = 1'b1;
    HostReq = 1'b1; HostWe = 1'b0; HostAddr = 16'd7;
    repeat (2) tick();
    chk("rst_mid_ack_up", 32'(HostAck), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("rst_mid_ack_down", 32'(HostAck), 32'd0);
    chk("rst_mid_idle", 32'(DbgHostState), 32'(HOST_IDLE));
    chk("rst_mid_core_rdata", 32'(CoreRData), 32'h0);
    HostReq = 1'b0;
    tick();
    Reset = 1'b1;
    tick();

    // contents preserved across reset
    host_xfer(1'b0, 16'd7, 16'h0000, d, lat);
    chk("keep_7", 32'(d), 32'hBEEF);
    HostMode = 1'b0;
    tick();
    core_read(16'h002A, d);
    chk("keep_2a", 32'(d), 32'(16'hC000 | 16'(10 * 16'h0111)));

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
